// File: rtl/mem_loader.sv
// mem_loader: byte-stream loader that writes framed words into instruction/data memory, then releases the CPU
module mem_loader #(
  parameter logic [7:0] IMEM_CMD = 8'h49,
  parameter logic [7:0] DMEM_CMD = 8'h44,
  parameter logic [7:0] GO_CMD = 8'h47
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [0:31] mem_addr,
  output logic [0:31] mem_wdata,
  output logic        imem_we,
  output logic        dmem_we,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);
  typedef enum logic [2:0] {CMD, ADDR, COUNT, DATA, WRITE, DONE, ERR} state_t;
  state_t state, next;
  logic [31:0] addr, word;
  logic [15:0] count;
  logic [1:0] bcnt;
  logic imem_sel;
  logic acc;
  assign acc = in_valid & in_ready;
  assign in_ready = state == CMD || state == ADDR || state == COUNT || state == DATA;
  assign imem_we = state == WRITE && imem_sel;
  assign dmem_we = state == WRITE && !imem_sel;
  assign cpu_hold = state != DONE;
  assign done = state == DONE;
  assign err = state == ERR;
  assign mem_addr = addr;
  assign mem_wdata = word;
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= CMD;
    else state <= next;
  // next-state decode; DONE and ERR have no exit
  always_comb begin
    next = state;
    case (state)
      CMD:   if (acc) next = (in_data == IMEM_CMD || in_data == DMEM_CMD) ? ADDR : (in_data == GO_CMD) ? DONE : ERR;
      ADDR:  if (acc && bcnt == 2'd3) next = COUNT;
      COUNT: if (acc && bcnt == 2'd1) next = ({count[7:0], in_data} == 16'd0) ? CMD : DATA;
      DATA:  if (acc && bcnt == 2'd3) next = WRITE;
      WRITE: next = (count == 16'd1) ? CMD : DATA;
      default: next = state;
    endcase
  end
  // field assembly; each field is shifted in MSB first so idle cycles simply hold it
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      addr <= '0;
      word <= '0;
      count <= '0;
      bcnt <= '0;
      imem_sel <= 1'b0;
    end else begin
      case (state)
        CMD:   if (acc) begin
          imem_sel <= in_data == IMEM_CMD;
          bcnt <= '0;
        end
        ADDR:  if (acc) begin
          addr <= {addr[23:0], in_data};
          bcnt <= bcnt + 2'd1;
        end
        COUNT: if (acc) begin
          count <= {count[7:0], in_data};
          bcnt <= (bcnt == 2'd1) ? 2'd0 : bcnt + 2'd1;
        end
        DATA:  if (acc) begin
          word <= {word[23:0], in_data};
          bcnt <= bcnt + 2'd1;
        end
        WRITE: begin
          addr <= addr + 32'd4;
          count <= count - 16'd1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed checks of framing, strobes, wrap, backpressure, errors and reset for mem_loader
module tb_mem_loader;
  logic clock, reset, in_valid, in_ready, imem_we, dmem_we, cpu_hold, done, err;
  logic [7:0] in_data;
  logic [0:31] mem_addr, mem_wdata;
  int tests = 0, fails = 0, nw = 0, base;
  bit gap_en = 0;

  mem_loader dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .imem_we(imem_we), .dmem_we(dmem_we),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  // count every cycle that carries a write strobe
  always @(negedge clock) if (imem_we || dmem_we) nw++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    if (gap_en) repeat ($urandom_range(0, 2)) begin
      in_valid = 0;
      in_data = 8'($urandom);
      step();
    end
    in_data = b;
    in_valid = 1;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 0;
  endtask

  task automatic send_hdr(input logic [7:0] c, input logic [31:0] a, input logic [15:0] n);
    send(c);
    for (int i = 3; i >= 0; i--) send(a[i*8 +: 8]);
    send(n[15:8]);
    send(n[7:0]);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] a, input logic im);
    for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
    chk("imem_we", {31'd0, imem_we}, {31'd0, im});
    chk("dmem_we", {31'd0, dmem_we}, {31'd0, !im});
    chk("mem_addr", mem_addr, a);
    chk("mem_wdata", mem_wdata, w);
    chk("ready_low_in_write", {31'd0, in_ready}, 32'd0);
    step();
    chk("ready_back", {31'd0, in_ready}, 32'd1);
    chk("strobe_one_cycle", {30'd0, imem_we, dmem_we}, 32'd0);
  endtask

  task automatic do_reset();
    in_valid = 0;
    reset = 1;
    #7;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_hold_done_err", {29'd0, cpu_hold, done, err}, 32'd4);
    chk("rst_strobes", {30'd0, imem_we, dmem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    @(negedge clock);
    reset = 0;
  endtask

  initial begin
    reset = 0;
    in_valid = 0;
    in_data = 0;
    #2;
    do_reset();
    // single IMEM word then GO
    base = nw;
    send_hdr(8'h49, 32'h0, 16'd1);
    send_word(32'h44000300, 32'h0, 1);
    send(8'h47);
    chk("imem_done", {31'd0, done}, 32'd1);
    chk("imem_hold", {31'd0, cpu_hold}, 32'd0);
    chk("imem_ready_done", {31'd0, in_ready}, 32'd0);
    chk("imem_nw", nw - base, 32'd1);
    // three DMEM words
    do_reset();
    base = nw;
    send_hdr(8'h44, 32'h2000, 16'd3);
    send_word(32'd1, 32'd8192, 0);
    send_word(32'd2, 32'd8196, 0);
    send_word(32'd3, 32'd8200, 0);
    chk("dmem_nw", nw - base, 32'd3);
    // zero count: straight back to CMD
    do_reset();
    base = nw;
    send_hdr(8'h44, 32'h2000, 16'd0);
    send(8'h47);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_nw", nw - base, 32'd0);
    // bad command is terminal
    do_reset();
    base = nw;
    send(8'h55);
    chk("bad_err", {31'd0, err}, 32'd1);
    chk("bad_ready", {31'd0, in_ready}, 32'd0);
    chk("bad_hold", {31'd0, cpu_hold}, 32'd1);
    in_valid = 1;
    in_data = 8'h49;
    repeat (3) step();
    in_data = 8'h47;
    repeat (3) step();
    in_valid = 0;
    chk("bad_sticky", {30'd0, err, done}, 32'd2);
    chk("bad_nw", nw - base, 32'd0);
    do_reset();
    chk("bad_cleared", {31'd0, err}, 32'd0);
    // address wrap
    send_hdr(8'h49, 32'hFFFFFFFC, 16'd2);
    send_word(32'hA5A5A5A5, 32'hFFFFFFFC, 1);
    send_word(32'h5A5A5A5A, 32'h00000000, 1);
    // backpressure with random gaps and garbage during idle
    do_reset();
    gap_en = 1;
    base = nw;
    send_hdr(8'h44, 32'h2000, 16'd3);
    send_word(32'd1, 32'd8192, 0);
    send_word(32'd2, 32'd8196, 0);
    send_word(32'd3, 32'd8200, 0);
    chk("bp_nw", nw - base, 32'd3);
    gap_en = 0;
    // reset after two data bytes discards the frame
    do_reset();
    base = nw;
    send_hdr(8'h44, 32'h2000, 16'd3);
    send(8'h00);
    send(8'h00);
    do_reset();
    repeat (6) step();
    chk("midrst_nw", nw - base, 32'd0);
    send_hdr(8'h49, 32'h10, 16'd1);
    send_word(32'hDEADBEEF, 32'h10, 1);
    chk("midrst_after_nw", nw - base, 32'd1);
    // reset landing inside WRITE cuts the strobe
    send_hdr(8'h44, 32'h40, 16'd1);
    for (int i = 3; i >= 0; i--) send(8'h11);
    chk("wr_pulse", {31'd0, dmem_we}, 32'd1);
    reset = 1;
    #1;
    chk("wr_cut", {30'd0, imem_we, dmem_we}, 32'd0);
    #3;
    @(negedge clock);
    reset = 0;
    repeat (3) step();
    chk("wr_cut_ready", {31'd0, in_ready}, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter IMEM_CMD, default 8'h49, the command byte that selects an instruction-memory load.
REQ-002 SHALL have parameter DMEM_CMD, default 8'h44, the command byte that selects a data-memory load.
REQ-003 SHALL have parameter GO_CMD, default 8'h47, the command byte that ends loading and releases the CPU.
REQ-004 SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous and active-high.
REQ-006 SHALL have port in_data, input, 8 bits, the byte-stream data.
REQ-007 SHALL have port in_valid, input, 1 bit; in_data is valid when high.
REQ-008 SHALL have port in_ready, output, 1 bit; a byte is accepted on a rising edge where in_valid and in_ready are both high.
REQ-009 SHALL have port mem_addr, output, [0:31], the byte address of the word being written.
REQ-010 SHALL have port mem_wdata, output, [0:31], the write word; bit 0 is the MSB.
REQ-011 SHALL have port imem_we, output, 1 bit, the instruction-memory write strobe.
REQ-012 SHALL have port dmem_we, output, 1 bit, the data-memory write strobe.
REQ-013 SHALL have port cpu_hold, output, 1 bit; while high, the pipeline is held in reset.
REQ-014 SHALL have port done, output, 1 bit; high once GO_CMD has been accepted.
REQ-015 SHALL have port err, output, 1 bit; sticky flag for a protocol error.

Function
REQ-016 SHALL implement states CMD, ADDR, COUNT, DATA, WRITE, DONE and ERR.
REQ-017 SHALL use this frame format: cmd byte, then 4 address bytes (big-endian), then 2 word-count bytes (big-endian), then count×4 data bytes.
REQ-018 SHALL handle each byte accepted in CMD as follows:
- IMEM_CMD or DMEM_CMD: latch the target and go to ADDR.
- GO_CMD: go to DONE.
- any other value: go to ERR.
REQ-019 SHALL, in ADDR, shift 4 accepted bytes into the address register with the first byte as MSB, then go to COUNT.
REQ-020 SHALL, in COUNT, shift 2 accepted bytes into a 16-bit count; if the count is 0 go to CMD, otherwise go to DATA.
REQ-021 SHALL, in DATA, assemble 4 accepted bytes big-endian; acceptance of the 4th byte moves the FSM to WRITE.
REQ-022 SHALL, in WRITE, hold exactly one cycle with these outputs:
- mem_addr = current address;
- mem_wdata = assembled word;
- the selected strobe (imem_we or dmem_we) high;
- in_ready low.
REQ-023 SHALL, after WRITE:
- add 4 to the address, modulo 2^32 (wraps from 32'hFFFFFFFC to 0);
- decrement the count;
- go to DATA if the count is nonzero, otherwise go to CMD.
REQ-024 SHALL keep imem_we and dmem_we mutually exclusive, and low in every state except WRITE.
REQ-025 SHALL drive in_ready high in CMD, ADDR, COUNT and DATA, and low in WRITE, DONE and ERR.
REQ-026 SHALL make the write latency one cycle: the strobe is high on the cycle immediately after the edge that accepts the 4th data byte.
REQ-027 SHALL keep byte order fixed and unaffected by gaps in in_valid; partial words and fields persist across idle cycles.
REQ-028 SHALL treat DONE and ERR as terminal states, left only via reset.
REQ-029 SHALL drive cpu_hold high in every state except DONE; in DONE, cpu_hold is low and done is high.
REQ-030 SHALL drive err high only in ERR; cpu_hold stays high in ERR.
REQ-031 SHALL allow any number of frames before GO_CMD, and a later frame SHALL overwrite earlier writes to the same address.
REQ-032 SHALL ignore in_data whenever in_valid is low.

Reset
REQ-033 SHALL, while reset is high, immediately and asynchronously force: state CMD; in_ready 1; cpu_hold 1; done 0; err 0; imem_we 0; dmem_we 0; mem_addr 0; mem_wdata 0; byte and word counters 0.
REQ-034 SHALL treat reset asserted mid-frame, including in WRITE, as follows:
- a strobe pulse in progress is cut short;
- the partial frame is discarded;
- no write occurs after reset is released.
REQ-035 SHALL accept the first byte on the first rising edge after reset is deasserted.

Verification
REQ-036 SHALL cover an IMEM load: stream 49 00000000 0001 44000300, then 47 -> one imem_we pulse with mem_addr=0 and mem_wdata=32'h44000300; then done=1 and cpu_hold=0.
REQ-037 SHALL cover a DMEM multi-word load: stream 44 00002000 0003 followed by words 1, 2, 3 -> dmem_we pulses at addresses 8192, 8196 and 8200 with data 1, 2, 3; in_ready is low for exactly one cycle after each word.
REQ-038 SHALL cover the zero-count case: stream 44 00002000 0000 then 47 -> no write strobe, done=1.
REQ-039 SHALL cover a bad command: stream byte 8'h55 -> err=1, in_ready=0, cpu_hold=1, and later bytes are ignored; after reset, err=0.
REQ-040 SHALL cover address wrap: a frame at start address FFFFFFFC with count 2 -> writes at FFFFFFFC and then 00000000.
REQ-041 SHALL cover backpressure and reset: in_valid toggled randomly during DATA gives the same writes as REQ-037; reset asserted after 2 data bytes -> no strobe, and the next frame writes correctly.
